// File: rtl/packer_10_16.sv
// Repacks a stream of 10-bit words into 16-bit link words, LSB-first with no gaps.
// Flush emits any pending partial word zero-padded; phase counts accepted inputs modulo 8.
module packer_10_16 (
  input  logic        clk,
  input  logic        rst,
  input  logic [9:0]  data_in,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        flush,
  output logic [15:0] data_out,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [2:0]  phase
);

  logic [25:0] acc;
  logic [3:0]  fill;
  logic        slot_free;
  logic        accept;
  logic        do_flush;
  logic        word_done;
  logic [4:0]  fill_sum;
  logic [25:0] merged;
  logic [15:0] flush_mask;

  // The output register is the only buffer; it frees up in the same cycle it retires.
  assign slot_free  = !out_valid || out_ready;
  assign in_ready   = slot_free;
  assign accept     = in_valid && slot_free;
  assign do_flush   = flush && !in_valid && slot_free;

  assign fill_sum   = {1'b0, fill} + 5'd10;
  assign word_done  = fill_sum[4];
  assign merged     = acc | ({16'd0, data_in} << fill);
  assign flush_mask = (16'd1 << fill) - 16'd1;

  always_ff @(posedge clk) begin
    if (rst) begin
      acc       <= '0;
      fill      <= '0;
      phase     <= '0;
      data_out  <= '0;
      out_valid <= 1'b0;
    end else if (accept) begin
      phase <= phase + 3'd1;
      // fill_sum[3:0] is fill+10-16 whenever a full word has formed
      fill  <= fill_sum[3:0];
      if (word_done) begin
        data_out  <= merged[15:0];
        out_valid <= 1'b1;
        acc       <= {16'd0, merged[25:16]};
      end else begin
        acc <= merged;
        if (out_ready) out_valid <= 1'b0;
      end
    end else if (do_flush) begin
      phase <= '0;
      if (fill != 4'd0) begin
        data_out  <= acc[15:0] & flush_mask;
        out_valid <= 1'b1;
        acc       <= '0;
        fill      <= '0;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_packer_10_16.sv
// Bench for packer_10_16: bit-queue reference model checked every cycle, plus directed
// literal expectations and a randomized valid/ready/flush run.
module tb_packer_10_16;

  logic        clk = 1'b0;
  logic        rst;
  logic [9:0]  data_in;
  logic        in_valid;
  logic        in_ready;
  logic        flush;
  logic [15:0] data_out;
  logic        out_valid;
  logic        out_ready;
  logic [2:0]  phase;

  int checks = 0;
  int failures = 0;

  packer_10_16 dut (
    .clk       (clk),
    .rst       (rst),
    .data_in   (data_in),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .flush     (flush),
    .data_out  (data_out),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .phase     (phase)
  );

  always #5 clk = ~clk;

  // Reference model: pending input bits LSB-first, words awaiting retirement, retired log.
  bit          bits_q[$];
  logic [15:0] exp_q[$];
  logic [15:0] seen[$];
  int unsigned acc_count = 0;
  bit          rst_seen = 1'b0;
  bit          stall_prev = 1'b0;
  logic [15:0] data_prev;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
    end
  endtask

  task automatic timeout_fail(input string name);
    checks++;
    failures++;
    $display("FAIL %s actual=timeout required=handshake at %0t", name, $time);
  endtask

  task automatic push_word();
    logic [15:0] w;
    w = '0;
    for (int i = 0; i < 16; i++) begin
      if (bits_q.size() > 0) w[i] = bits_q.pop_front();
    end
    exp_q.push_back(w);
  endtask

  always @(negedge clk) begin
    bit model_slot;
    logic [15:0] w;
    model_slot = (exp_q.size() == 0) || (out_ready == 1'b1);
    if (rst_seen) begin
      chk("reset_data_out", {16'd0, data_out}, 32'd0);
      chk("reset_out_valid", {31'd0, out_valid}, 32'd0);
      chk("reset_in_ready", {31'd0, in_ready}, 32'd1);
      chk("reset_phase", {29'd0, phase}, 32'd0);
    end else if (!rst) begin
      chk("in_ready", {31'd0, in_ready}, {31'd0, model_slot});
      chk("phase", {29'd0, phase}, acc_count % 8);
      chk("out_valid", {31'd0, out_valid}, {31'd0, exp_q.size() != 0});
      if (stall_prev) chk("hold_data_out", {16'd0, data_out}, {16'd0, data_prev});
      if (out_valid && out_ready && exp_q.size() > 0) begin
        w = exp_q.pop_front();
        chk("data_out", {16'd0, data_out}, {16'd0, w});
        seen.push_back(data_out);
      end
    end
    stall_prev = out_valid && !out_ready && !rst && !rst_seen;
    data_prev  = data_out;
    rst_seen   = rst;
    if (rst) begin
      bits_q.delete();
      exp_q.delete();
      acc_count = 0;
    end else if (in_valid && model_slot) begin
      for (int i = 0; i < 10; i++) bits_q.push_back(data_in[i]);
      acc_count++;
      while (bits_q.size() >= 16) push_word();
    end else if (flush && !in_valid && model_slot) begin
      if (bits_q.size() > 0) push_word();
      bits_q.delete();
      acc_count = 0;
    end
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send(input logic [9:0] w);
    bit ok;
    ok = 1'b0;
    data_in  = w;
    in_valid = 1'b1;
    for (int n = 0; n < 200; n++) begin
      @(negedge clk);
      if (in_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) timeout_fail("send_wait");
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic do_flush();
    bit ok;
    ok = 1'b0;
    in_valid = 1'b0;
    flush    = 1'b1;
    for (int n = 0; n < 200; n++) begin
      @(negedge clk);
      if (in_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) timeout_fail("flush_wait");
    @(posedge clk);
    #1;
    flush = 1'b0;
  endtask

  task automatic expect_seen(input string name, input int n, input logic [15:0] val);
    chk({name, "_count"}, seen.size(), n);
    foreach (seen[i]) chk({name, "_word"}, {16'd0, seen[i]}, {16'd0, val});
  endtask

  initial begin
    int  sent;
    bit  took;
    rst = 1'b1; data_in = '0; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
    idle(3);
    rst = 1'b0;
    idle(1);

    // Eight all-ones inputs -> five all-ones words, phase back at 0.
    seen.delete();
    repeat (8) send(10'h3FF);
    idle(2);
    expect_seen("ones", 5, 16'hFFFF);
    chk("ones_phase", {29'd0, phase}, 32'd0);

    // 3FF, 001 -> 07FF; flush of the remaining four zero bits -> 0000.
    seen.delete();
    send(10'h3FF);
    send(10'h001);
    do_flush();
    idle(2);
    chk("pair_count", seen.size(), 2);
    if (seen.size() == 2) begin
      chk("pair_w0", {16'd0, seen[0]}, 32'h07FF);
      chk("pair_w1", {16'd0, seen[1]}, 32'h0000);
    end
    chk("pair_phase", {29'd0, phase}, 32'd0);

    // Single word then flush -> 0155 visible right after the flush edge.
    seen.delete();
    send(10'h155);
    do_flush();
    chk("single_valid", {31'd0, out_valid}, 32'd1);
    chk("single_data", {16'd0, data_out}, 32'h0155);
    chk("single_phase", {29'd0, phase}, 32'd0);
    idle(2);

    // Backpressure after the first word of a 2AA burst.
    seen.delete();
    send(10'h2AA);
    send(10'h2AA);
    out_ready = 1'b0;
    data_in   = 10'h2AA;
    in_valid  = 1'b1;
    idle(4);
    chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
    chk("bp_valid", {31'd0, out_valid}, 32'd1);
    chk("bp_data", {16'd0, data_out}, 32'hAAAA);
    out_ready = 1'b1;
    repeat (6) send(10'h2AA);
    idle(2);
    expect_seen("bp", 5, 16'hAAAA);

    // Reset mid-cycle discards partial state.
    repeat (3) send(10'($urandom));
    rst = 1'b1;
    idle(1);
    rst = 1'b0;
    chk("mid_rst_valid", {31'd0, out_valid}, 32'd0);
    chk("mid_rst_phase", {29'd0, phase}, 32'd0);
    seen.delete();
    repeat (8) send(10'h3FF);
    idle(2);
    expect_seen("post_rst", 5, 16'hFFFF);

    // Randomized valid/ready/flush traffic over 800 accepted words.
    sent = 0;
    for (int cyc = 0; cyc < 20000 && sent < 800; cyc++) begin
      @(negedge clk);
      took = in_valid && in_ready;
      @(posedge clk);
      #1;
      if (took) begin
        in_valid = 1'b0;
        sent++;
      end
      out_ready = ($urandom_range(0, 3) != 0);
      if (!in_valid) begin
        if ($urandom_range(0, 3) != 0 && sent < 800) begin
          data_in  = 10'($urandom);
          in_valid = 1'b1;
          flush    = 1'b0;
        end else begin
          flush = ($urandom_range(0, 15) == 0);
        end
      end
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    if (sent < 800) timeout_fail("random_budget");
    do_flush();
    idle(3);
    chk("drain_words", exp_q.size(), 0);
    chk("drain_bits", bits_q.size(), 0);
    chk("drain_valid", {31'd0, out_valid}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
